// File: rtl/pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_sequencer
// Description : Writes a selected PLL profile over the Avalon-MM mgmt port of
//               the PLL reconfig core, triggers reconfiguration and polls
//               status until completion or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_sequencer #(
    parameter  int NUM_PROFILES = 4,
    parameter  int NUM_C        = 2,
    parameter  int WRITE_GAP    = 2,
    parameter  int POLL_TIMEOUT = 4096,
    localparam int SEL_W        = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [SEL_W-1:0]                profile_sel,
    input  logic [18*NUM_PROFILES-1:0]      prof_m,
    input  logic [18*NUM_PROFILES-1:0]      prof_n,
    input  logic [18*NUM_C*NUM_PROFILES-1:0] prof_c,
    input  logic [4*NUM_PROFILES-1:0]       prof_bw,
    input  logic [3*NUM_PROFILES-1:0]       prof_cp,
    input  logic                            mgmt_waitrequest,
    input  logic [31:0]                     mgmt_readdata,
    output logic                            mgmt_read,
    output logic                            mgmt_write,
    output logic [5:0]                      mgmt_address,
    output logic [31:0]                     mgmt_writedata,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [SEL_W-1:0]                active_profile
);

    localparam int STEP_W    = 5;
    localparam int LAST_STEP = NUM_C + 5;
    // A zero gap still needs one low cycle so every write is a distinct transaction.
    localparam int GAP_CYC   = (WRITE_GAP == 0) ? 1 : WRITE_GAP;
    localparam int GAP_W     = $clog2(GAP_CYC + 1);
    localparam int PT_W      = $clog2(POLL_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2,
        S_POLL  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [STEP_W-1:0]   step_q,     step_d;
    logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
    logic [PT_W-1:0]     poll_cnt_q, poll_cnt_d;
    logic [SEL_W-1:0]    prof_q,     prof_d;
    logic                read_q,     read_d;
    logic                write_q,    write_d;
    logic [5:0]          addr_q,     addr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                error_q,    error_d;
    logic [SEL_W-1:0]    active_q,   active_d;

    logic [STEP_W-1:0]   w_step;
    logic [STEP_W-1:0]   w_k;
    logic [STEP_W-1:0]   w_c_sel;
    logic [17:0]         w_m;
    logic [17:0]         w_n;
    logic [17:0]         w_c;
    logic [3:0]          w_bw;
    logic [2:0]          w_cp;
    logic [5:0]          w_addr;
    logic [31:0]         w_data;
    logic                w_unused_rd;

    assign w_unused_rd = ^mgmt_readdata[31:1];

    // Step about to be issued: step 0 from IDLE, otherwise the one after the current.
    assign w_step = (state_q == S_IDLE) ? '0 : step_q + STEP_W'(1);

    always_comb begin
        w_k     = w_step - STEP_W'(3);
        w_c_sel = (w_k < STEP_W'(NUM_C)) ? w_k : '0;
        w_m     = prof_m[18*int'(prof_q) +: 18];
        w_n     = prof_n[18*int'(prof_q) +: 18];
        w_c     = prof_c[18*(int'(prof_q)*NUM_C + int'(w_c_sel)) +: 18];
        w_bw    = prof_bw[4*int'(prof_q) +: 4];
        w_cp    = prof_cp[3*int'(prof_q) +: 3];
        w_addr  = 6'h02;
        w_data  = 32'h1;
        if (w_step == STEP_W'(0)) begin
            w_addr = 6'h00;
            w_data = 32'h1;
        end else if (w_step == STEP_W'(1)) begin
            w_addr = 6'h04;
            w_data = {14'h0, w_m};
        end else if (w_step == STEP_W'(2)) begin
            w_addr = 6'h03;
            w_data = {14'h0, w_n};
        end else if (w_step < STEP_W'(NUM_C + 3)) begin
            w_addr = 6'h05;
            w_data = {9'h0, w_k, w_c};
        end else if (w_step == STEP_W'(NUM_C + 3)) begin
            w_addr = 6'h08;
            w_data = {28'h0, w_bw};
        end else if (w_step == STEP_W'(NUM_C + 4)) begin
            w_addr = 6'h09;
            w_data = {29'h0, w_cp};
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        prof_d     = prof_q;
        read_d     = read_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        active_d   = active_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (int'(profile_sel) < NUM_PROFILES) begin
                        prof_d  = profile_sel;
                        busy_d  = 1'b1;
                        step_d  = '0;
                        write_d = 1'b1;
                        addr_d  = w_addr;
                        wdata_d = w_data;
                        state_d = S_WRITE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (!mgmt_waitrequest) begin
                    write_d   = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    if (step_q == STEP_W'(LAST_STEP)) begin
                        read_d     = 1'b1;
                        addr_d     = 6'h01;
                        wdata_d    = '0;
                        poll_cnt_d = '0;
                        state_d    = S_POLL;
                    end else begin
                        step_d  = w_step;
                        write_d = 1'b1;
                        addr_d  = w_addr;
                        wdata_d = w_data;
                        state_d = S_WRITE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_POLL: begin
                poll_cnt_d = poll_cnt_q + PT_W'(1);
                if (read_q && !mgmt_waitrequest && mgmt_readdata[0]) begin
                    read_d   = 1'b0;
                    done_d   = 1'b1;
                    active_d = prof_q;
                    busy_d   = 1'b0;
                    addr_d   = '0;
                    state_d  = S_IDLE;
                end else if (poll_cnt_q == PT_W'(POLL_TIMEOUT - 1)) begin
                    read_d  = 1'b0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else if (read_q && !mgmt_waitrequest) begin
                    read_d = 1'b0;
                end else begin
                    read_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            prof_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            prof_q     <= prof_d;
            read_q     <= read_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            active_q   <= active_d;
        end
    end

    assign mgmt_read      = read_q;
    assign mgmt_write     = write_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign active_profile = active_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reconfig_sequencer
// Description : Directed self-checking bench with a reactive mgmt slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_sequencer;

    localparam logic [37:0] EXP2 [8] = '{
        {6'h00, 32'h0000_0001}, {6'h04, 32'h0000_00A2}, {6'h03, 32'h0000_00B2},
        {6'h05, 32'h0003_0020}, {6'h05, 32'h0007_0021}, {6'h08, 32'h0000_000A},
        {6'h09, 32'h0000_0003}, {6'h02, 32'h0000_0001}};
    localparam logic [37:0] EXP3 [8] = '{
        {6'h00, 32'h0000_0001}, {6'h04, 32'h0000_00A3}, {6'h03, 32'h0000_00B3},
        {6'h05, 32'h0003_0030}, {6'h05, 32'h0007_0031}, {6'h08, 32'h0000_000B},
        {6'h09, 32'h0000_0004}, {6'h02, 32'h0000_0001}};

    logic clk, rst0, rst1;

    logic         start0, wreq0, rd0, wr0, busy0, done0, err0;
    logic [1:0]   sel0, act_p0;
    logic [71:0]  m0, n0;
    logic [143:0] c0;
    logic [15:0]  bw0;
    logic [11:0]  cp0;
    logic [31:0]  rdata0, wd0;
    logic [5:0]   addr0;

    logic         start1, wreq1, rd1, wr1, busy1, done1, err1;
    logic [1:0]   sel1, act_p1;
    logic [53:0]  m1, n1;
    logic [107:0] c1;
    logic [11:0]  bw1;
    logic [8:0]   cp1;
    logic [31:0]  rdata1, wd1;
    logic [5:0]   addr1;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int act0 = 0, act1 = 0, done_n0 = 0, done_n1 = 0, err_n0 = 0, err_n1 = 0;
    int busy_n1 = 0, ovl = 0, m_cyc0 = 0, m_bad0 = 0;
    int rd_cnt0 = 0, rd_cnt1 = 0, lock0 = 0, lock1 = 0, wait_left = 0;
    int poll_cyc1 = 0, err_cyc1 = 0;
    bit rd_seen1 = 1'b0;
    logic [31:0] exp_m0 = 32'hA2;
    logic [37:0] q0 [$];

    pll_reconfig_sequencer u_dut0 (
        .clk(clk), .reset(rst0), .start(start0), .profile_sel(sel0),
        .prof_m(m0), .prof_n(n0), .prof_c(c0), .prof_bw(bw0), .prof_cp(cp0),
        .mgmt_waitrequest(wreq0), .mgmt_readdata(rdata0),
        .mgmt_read(rd0), .mgmt_write(wr0), .mgmt_address(addr0), .mgmt_writedata(wd0),
        .busy(busy0), .done(done0), .error(err0), .active_profile(act_p0));

    pll_reconfig_sequencer #(.NUM_PROFILES(3), .POLL_TIMEOUT(16)) u_dut1 (
        .clk(clk), .reset(rst1), .start(start1), .profile_sel(sel1),
        .prof_m(m1), .prof_n(n1), .prof_c(c1), .prof_bw(bw1), .prof_cp(cp1),
        .mgmt_waitrequest(wreq1), .mgmt_readdata(rdata1),
        .mgmt_read(rd1), .mgmt_write(wr1), .mgmt_address(addr1), .mgmt_writedata(wd1),
        .busy(busy1), .done(done1), .error(err1), .active_profile(act_p1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model and bus monitor, evaluated mid-cycle for the next rising edge.
    initial begin
        wreq0 = 1'b0; rdata0 = '0; wreq1 = 1'b0; rdata1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr0 && addr0 == 6'h04 && wait_left > 0) begin
                wreq0 = 1'b1;
                wait_left--;
            end else begin
                wreq0 = 1'b0;
            end
            if (rd0 && !wreq0) begin
                rd_cnt0++;
                rdata0 = (rd_cnt0 == lock0) ? 32'h1 : 32'h0;
            end
            if (rd1) begin
                rd_cnt1++;
                rdata1 = (lock1 != 0 && rd_cnt1 == lock1) ? 32'h1 : 32'h0;
                if (!rd_seen1) begin
                    poll_cyc1 = cyc;
                    rd_seen1  = 1'b1;
                end
            end
            if (wr0 || rd0) act0++;
            if (wr1 || rd1) act1++;
            if (wr0 && addr0 == 6'h04) begin
                m_cyc0++;
                if (wd0 != exp_m0) m_bad0++;
            end
            if (wr0 && !wreq0) q0.push_back({addr0, wd0});
            if (done0) done_n0++;
            if (done1) done_n1++;
            if (err0) err_n0++;
            if (err1) begin
                err_n1++;
                err_cyc1 = cyc;
            end
            if (busy1) busy_n1++;
            if ((rd0 && wr0) || (rd1 && wr1) || (done0 && err0) || (done1 && err1)) ovl++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [1:0] s);
        start0 = 1'b1; sel0 = s;
        tick(1);
        start0 = 1'b0;
    endtask

    task automatic pulse1(input logic [1:0] s);
        start1 = 1'b1; sel1 = s;
        tick(1);
        start1 = 1'b0;
    endtask

    task automatic cmp_seq(input string tag, input logic [37:0] exp [8]);
        check({tag, "_count"}, q0.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_w%0d", tag, i), (i < q0.size()) ? q0[i] : '1, exp[i]);
    endtask

    initial begin
        int d, a;
        start0 = 1'b0; sel0 = '0; start1 = 1'b0; sel1 = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        for (int p = 0; p < 4; p++) begin
            m0[18*p +: 18] = 18'h0A0 + 18'(p);
            n0[18*p +: 18] = 18'h0B0 + 18'(p);
            for (int k = 0; k < 2; k++) c0[18*(2*p+k) +: 18] = 18'h30000 + 18'(16*p + k);
            bw0[4*p +: 4] = 4'h8 + 4'(p);
            cp0[3*p +: 3] = 3'(p + 1);
        end
        m1 = m0[53:0]; n1 = n0[53:0]; c1 = c0[107:0]; bw1 = bw0; cp1 = cp0[8:0];
        tick(3);
        check("rst_outs0", {busy0, done0, err0, rd0, wr0, act_p0, addr0, wd0}, 0);
        check("rst_outs1", {busy1, done1, err1, rd1, wr1, act_p1, addr1, wd1}, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick(2);

        // Basic profile-2 sequence, lock on third read
        q0.delete(); rd_cnt0 = 0; lock0 = 3; d = done_n0;
        pulse0(2);
        check("t1_busy", busy0, 1);
        for (int i = 0; i < 400 && done_n0 == d; i++) tick(1);
        check("t1_done_hi", {done0, err0}, 2'b10);
        cmp_seq("t1", EXP2);
        check("t1_reads", rd_cnt0, 3);
        tick(1);
        check("t1_done_pulse", done0, 0);
        check("t1_active", act_p0, 2);
        check("t1_busy_end", busy0, 0);

        // Stall on the M write
        q0.delete(); rd_cnt0 = 0; lock0 = 1; wait_left = 3; m_cyc0 = 0; m_bad0 = 0;
        exp_m0 = 32'hA2; d = done_n0;
        pulse0(2);
        for (int i = 0; i < 400 && done_n0 == d; i++) tick(1);
        check("t2_done", done_n0 - d, 1);
        check("t2_m_cycles", m_cyc0, 4);
        check("t2_m_stable", m_bad0, 0);
        cmp_seq("t2", EXP2);

        // Start while busy is ignored
        q0.delete(); rd_cnt0 = 0; lock0 = 2; d = done_n0;
        pulse0(3);
        tick(4);
        pulse0(1);
        for (int i = 0; i < 400 && done_n0 == d; i++) tick(1);
        check("t6_done", done_n0 - d, 1);
        cmp_seq("t6", EXP3);
        tick(1);
        check("t6_active", act_p0, 3);
        tick(5);
        check("t6_no_requeue", busy0, 0);

        // Reset during BW write
        q0.delete(); rd_cnt0 = 0; lock0 = 1;
        pulse0(2);
        for (int i = 0; i < 200 && !(wr0 && addr0 == 6'h08); i++) tick(1);
        check("t5_bw_seen", {wr0, addr0}, {1'b1, 6'h08});
        rst0 = 1'b1;
        #1;
        check("t5_rst_outs", {busy0, done0, err0, rd0, wr0, act_p0, addr0, wd0}, 0);
        tick(2);
        rst0 = 1'b0;
        a = act0;
        tick(40);
        check("t5_no_access", act0 - a, 0);
        check("t5_idle", {busy0, act_p0}, 0);

        // Out-of-range profile on a 3-profile instance
        d = err_n1;
        pulse1(3);
        check("t3_err_hi", err1, 1);
        tick(5);
        check("t3_err_once", err_n1 - d, 1);
        check("t3_no_access", act1, 0);
        check("t3_no_busy", busy_n1, 0);

        // Valid run establishes active profile 1
        rd_cnt1 = 0; lock1 = 1; d = done_n1;
        pulse1(1);
        for (int i = 0; i < 400 && done_n1 == d; i++) tick(1);
        check("t4_pre_done", done_n1 - d, 1);
        tick(1);
        check("t4_pre_active", act_p1, 1);

        // Poll never completes: timeout
        rd_cnt1 = 0; lock1 = 0; rd_seen1 = 1'b0; d = err_n1; a = done_n1;
        pulse1(2);
        for (int i = 0; i < 400 && err_n1 == d; i++) tick(1);
        check("t4_err", err_n1 - d, 1);
        check("t4_latency", err_cyc1 - poll_cyc1, 16);
        tick(2);
        check("t4_no_done", done_n1 - a, 0);
        check("t4_active", act_p1, 1);
        check("t4_busy_end", {busy1, rd1}, 0);

        check("overlap", ovl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
